// File: rtl/lamp_conflict_monitor.sv
// lamp_conflict_monitor: registers controller lamp codes, flags unsafe combinations and
// forces flashing red on all approaches until an operator clears the latched fault
module lamp_conflict_monitor #(
  parameter int MIN_YEL = 2,
  parameter int STUCK_MAX = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] nl_in,
  input  logic [2:0] sl_in,
  input  logic [2:0] el_in,
  input  logic [2:0] wl_in,
  input  logic       fault_clr,
  output logic [2:0] nl_out,
  output logic [2:0] sl_out,
  output logic [2:0] el_out,
  output logic [2:0] wl_out,
  output logic       fault,
  output logic [2:0] fault_code
);
  localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100;
  localparam int YW = $clog2(MIN_YEL + 1);
  localparam int SW = $clog2(STUCK_MAX + 1);
  localparam logic [YW-1:0] YEL_SAT = YW'(MIN_YEL);
  localparam logic [SW-1:0] STALL_SAT = SW'(STUCK_MAX);
  localparam logic [SW-1:0] STALL_LAST = SW'(STUCK_MAX - 1);
  logic [3:0][2:0] in_q, prv_q, lamp_q;
  logic [3:0][YW-1:0] yel_cnt;
  logic [SW-1:0] stall_cnt;
  logic flash_ph, multi, same, clr_ok;
  logic [3:0] bad_enc, not_red, bad_step, short_yel, yel_enter;
  logic [2:0] code;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign bad_enc[i] = !$onehot(in_q[i]);
    assign not_red[i] = in_q[i] != R;
    assign bad_step[i] = !(in_q[i] == prv_q[i] || (prv_q[i] == R && in_q[i] == G) ||
                           (prv_q[i] == G && in_q[i] == Y) || (prv_q[i] == Y && in_q[i] == R));
    assign short_yel[i] = prv_q[i] == Y && in_q[i] == R && yel_cnt[i] < YEL_SAT;
    assign yel_enter[i] = in_q[i] == Y && prv_q[i] != Y;
  end
  assign multi = |(not_red & (not_red - 4'd1));
  assign same = in_q == prv_q;
  // stall fires on the tick that would take the counter to STUCK_MAX
  assign code = |bad_enc ? 3'd1 : multi ? 3'd2 : |bad_step ? 3'd3 : |short_yel ? 3'd4 :
                (tick && same && stall_cnt == STALL_LAST) ? 3'd5 : 3'd0;
  assign clr_ok = fault && fault_clr && not_red == 4'd0 && code == 3'd0;
  assign {wl_out, el_out, sl_out, nl_out} = lamp_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      in_q <= {4{R}};
      prv_q <= {4{R}};
      lamp_q <= {4{R}};
      yel_cnt <= '0;
      stall_cnt <= '0;
      flash_ph <= 1'b1;
      fault <= 1'b0;
      fault_code <= 3'd0;
    end else begin
      prv_q <= in_q;
      in_q <= {wl_in, el_in, sl_in, nl_in};
      for (int i = 0; i < 4; i++)
        if (yel_enter[i]) yel_cnt[i] <= '0;
        else if (in_q[i] == Y && tick && yel_cnt[i] != YEL_SAT) yel_cnt[i] <= yel_cnt[i] + 1'b1;
      if (!same) stall_cnt <= '0;
      else if (tick && stall_cnt != STALL_SAT) stall_cnt <= stall_cnt + 1'b1;
      if (!fault && code != 3'd0) begin
        fault <= 1'b1;
        fault_code <= code;
        flash_ph <= 1'b1;
        stall_cnt <= '0;
        lamp_q <= {4{R}};
      end else if (clr_ok) begin
        fault <= 1'b0;
        fault_code <= 3'd0;
        yel_cnt <= '0;
        stall_cnt <= '0;
        lamp_q <= {4{R}};
      end else if (fault) begin
        flash_ph <= flash_ph ^ tick;
        lamp_q <= {4{(flash_ph ^ tick) ? R : 3'b000}};
      end else lamp_q <= in_q;
    end
endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// tb_lamp_conflict_monitor: directed lamp sequences checked every cycle against a rule model,
// plus literal spot checks at the points where the expected behaviour is known by hand
module tb_lamp_conflict_monitor;
  localparam int MIN_YEL = 2, STUCK_MAX = 30;
  localparam logic [2:0] G = 3'b001, Y = 3'b010, R = 3'b100, X = 3'b000;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, fault_clr = 1'b0;
  logic [2:0] nl_in = R, sl_in = R, el_in = R, wl_in = R;
  logic [2:0] nl_out, sl_out, el_out, wl_out, fault_code;
  logic fault;
  int total = 0, bad = 0;
  logic [2:0] m_cur[4], m_prev[4], m_out[4];
  int m_yt[4];
  int m_idle;
  logic m_fault, m_flash;
  logic [2:0] m_code;

  lamp_conflict_monitor #(.MIN_YEL(MIN_YEL), .STUCK_MAX(STUCK_MAX)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .nl_in(nl_in), .sl_in(sl_in), .el_in(el_in), .wl_in(wl_in),
    .fault_clr(fault_clr),
    .nl_out(nl_out), .sl_out(sl_out), .el_out(el_out), .wl_out(wl_out),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] lamps();
    return {wl_out, el_out, sl_out, nl_out};
  endfunction

  function automatic logic [2:0] nxt_col(input logic [2:0] c);
    return c == R ? G : c == G ? Y : c == Y ? R : 3'b111;
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cur[i] = R; m_prev[i] = R; m_out[i] = R; m_yt[i] = 0;
    end
    m_idle = 0; m_fault = 0; m_flash = 1; m_code = 0;
  endtask

  // what the monitor must do at one clock edge, given the sample pair it holds
  task automatic model_step(input logic t, input logic c, input logic [11:0] smp);
    logic [2:0] v;
    int nr;
    logic enc, stp, sy, same, allr;
    nr = 0; enc = 0; stp = 0; sy = 0; same = 1; allr = 1;
    for (int i = 0; i < 4; i++) begin
      if (!(m_cur[i] inside {G, Y, R})) enc = 1;
      if (m_cur[i] != R) begin nr++; allr = 0; end
      if (m_cur[i] != m_prev[i]) begin
        same = 0;
        if (m_cur[i] != nxt_col(m_prev[i])) stp = 1;
      end
      if (m_prev[i] == Y && m_cur[i] == R && m_yt[i] < MIN_YEL) sy = 1;
    end
    v = enc ? 3'd1 : nr > 1 ? 3'd2 : stp ? 3'd3 : sy ? 3'd4 :
        (t && same && m_idle + 1 == STUCK_MAX) ? 3'd5 : 3'd0;
    for (int i = 0; i < 4; i++)
      if (m_cur[i] == Y && m_prev[i] != Y) m_yt[i] = 0;
      else if (m_cur[i] == Y && t) m_yt[i]++;
    if (!same) m_idle = 0;
    else if (t) m_idle++;
    if (!m_fault && v != 0) begin
      m_fault = 1; m_code = v; m_flash = 1; m_idle = 0;
      for (int i = 0; i < 4; i++) m_out[i] = R;
    end else if (m_fault && c && allr && v == 0) begin
      m_fault = 0; m_code = 0; m_idle = 0;
      for (int i = 0; i < 4; i++) begin m_yt[i] = 0; m_out[i] = R; end
    end else if (m_fault) begin
      if (t) m_flash = !m_flash;
      for (int i = 0; i < 4; i++) m_out[i] = m_flash ? R : X;
    end else
      for (int i = 0; i < 4; i++) m_out[i] = m_cur[i];
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = m_cur[i];
      m_cur[i] = smp[i*3 +: 3];
    end
  endtask

  task automatic cyc(input logic t, input logic [2:0] n, s, e, w, input logic c);
    nl_in = n; sl_in = s; el_in = e; wl_in = w; tick = t; fault_clr = c;
    @(posedge clk);
    model_step(t, c, {w, e, s, n});
    #1;
    chk("lamps", lamps(), {m_out[3], m_out[2], m_out[1], m_out[0]});
    chk("fault", 12'(fault), 12'(m_fault));
    chk("code", 12'(fault_code), 12'(m_code));
  endtask

  task automatic run(input int k, input logic [2:0] n, s, e, w, input logic c);
    for (int j = 0; j < k; j++) begin
      repeat (3) cyc(1'b0, n, s, e, w, c);
      cyc(1'b1, n, s, e, w, c);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; tick = 0; fault_clr = 0;
    nl_in = R; sl_in = R; el_in = R; wl_in = R;
    #1;
    chk("rst_lamps", lamps(), 12'h924);
    chk("rst_fault", 12'(fault), 12'h0);
    chk("rst_code", 12'(fault_code), 12'h0);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    do_reset();
    run(8, G, R, R, R, 0);
    chk("norm_green", lamps(), 12'h921);
    run(3, Y, R, R, R, 0);
    chk("norm_yellow", lamps(), 12'h922);
    run(3, R, R, R, R, 0);
    chk("norm_red", lamps(), 12'h924);
    chk("norm_fault", 12'(fault), 12'h0);

    do_reset();
    cyc(0, R, R, R, R, 0);
    cyc(0, G, R, G, R, 0);
    chk("conf_pre", 12'(fault), 12'h0);
    cyc(0, G, R, G, R, 0);
    chk("conf_fault", 12'(fault), 12'h1);
    chk("conf_code", 12'(fault_code), 12'h2);
    chk("conf_lamps", lamps(), 12'h924);
    cyc(0, G, R, G, R, 0);
    cyc(0, G, R, G, R, 0);
    cyc(1, G, R, G, R, 0);
    chk("flash_off", lamps(), 12'h000);
    run(1, G, R, G, R, 0);
    chk("flash_on", lamps(), 12'h924);
    run(1, G, R, R, R, 1);
    chk("clr_ignored", 12'(fault), 12'h1);
    chk("clr_ignored_code", 12'(fault_code), 12'h2);
    cyc(0, R, R, R, R, 1);
    cyc(0, R, R, R, R, 1);
    chk("clr_blocked_step", 12'(fault), 12'h1);
    cyc(0, R, R, R, R, 1);
    chk("clr_fault", 12'(fault), 12'h0);
    chk("clr_code", 12'(fault_code), 12'h0);
    chk("clr_lamps", lamps(), 12'h924);
    cyc(0, R, R, R, R, 0);
    cyc(0, G, R, R, R, 0);
    cyc(0, G, R, R, R, 0);
    chk("resume", lamps(), 12'h921);

    do_reset();
    run(2, G, R, R, R, 0);
    cyc(0, R, R, R, R, 0);
    chk("step_pre", lamps(), 12'h921);
    cyc(0, R, R, R, R, 0);
    chk("step_code", 12'(fault_code), 12'h3);
    chk("step_lamps", lamps(), 12'h924);

    do_reset();
    cyc(0, X, R, R, R, 0);
    cyc(0, X, R, R, R, 0);
    chk("enc_fault", 12'(fault), 12'h1);
    chk("enc_code", 12'(fault_code), 12'h1);

    do_reset();
    run(2, G, R, R, R, 0);
    run(1, Y, R, R, R, 0);
    cyc(0, R, R, R, R, 0);
    chk("shorty_pre", lamps(), 12'h922);
    cyc(0, R, R, R, R, 0);
    chk("shorty_code", 12'(fault_code), 12'h4);

    do_reset();
    run(2, G, R, R, R, 0);
    run(2, Y, R, R, R, 0);
    run(2, R, R, R, R, 0);
    chk("longy_fault", 12'(fault), 12'h0);
    chk("longy_lamps", lamps(), 12'h924);

    do_reset();
    run(29, R, R, R, R, 0);
    chk("stall_29", 12'(fault), 12'h0);
    run(1, R, R, R, R, 0);
    chk("stall_30", 12'(fault), 12'h1);
    chk("stall_code", 12'(fault_code), 12'h5);
    cyc(0, R, R, R, R, 0);
    cyc(0, R, R, R, R, 0);
    cyc(1, R, R, R, R, 0);
    chk("stall_flash", lamps(), 12'h000);

    do_reset();
    run(28, R, R, R, R, 0);
    run(1, G, R, R, R, 0);
    run(5, G, R, R, R, 0);
    chk("stall_avoid", 12'(fault), 12'h0);
    chk("stall_avoid_lamps", lamps(), 12'h921);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
